sequence_insert_ctrl: RTL and testbench

SEQUENCE_INSERT_CTRL -- requirements
Module: sequence_insert_ctrl

---
 rtl/sequence_insert_ctrl.sv | 162 ++++++++++++++++
 tb/tb_sequence_insert_ctrl.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/sequence_insert_ctrl.sv
// Test-sequence insertion controller: counts lines after each field start and
// opens a generator window on one line. Optional macro SEQ_LFSR_ADVANCE_EN.
module sequence_insert_ctrl #(
  parameter int TARGET_LINE    = 10,
  parameter int ACTIVE_SAMPLES = 1440,
  parameter int LOAD_CYCLES    = 36,
  parameter int LINE_W         = 10
) (
  input  logic        clock,
  input  logic        rst_n,
  input  logic        field_start,
  input  logic        sav,
  input  logic        eav,
  input  logic [31:0] seq_in,
  input  logic        seq_in_valid,
  output logic        seq_in_ready,
  output logic [31:0] seq_word,
  output logic        gen_enable,
  output logic        gen_load,
  output logic        insert_sel,
  output logic        err_short
);

  localparam int WIN_W = $clog2(ACTIVE_SAMPLES + 1);
  localparam logic [WIN_W-1:0]  WIN_LAST    = WIN_W'(ACTIVE_SAMPLES);
  localparam logic [WIN_W-1:0]  LOAD_LAST   = WIN_W'(LOAD_CYCLES);
  localparam logic [LINE_W-1:0] TARGET      = LINE_W'(TARGET_LINE);
  localparam logic              LOAD_AT_SAV = (LOAD_CYCLES > 0);

  typedef enum logic [1:0] {IDLE, COUNT, INSERT, DONE} state_t;

  state_t            state_reg, state_next;
  logic [LINE_W-1:0] line_cnt_reg, line_cnt_next;
  logic [WIN_W-1:0]  win_cnt_reg, win_cnt_next;
  logic              enable_reg, enable_next;
  logic              load_reg, load_next;
  logic              err_reg, err_next;
  logic [31:0]       shadow_reg, shadow_next;
  logic              shadow_full_reg, shadow_full_next;
  logic [31:0]       seq_word_reg, seq_word_next;

`ifdef SEQ_LFSR_ADVANCE_EN
  // Right-shifting Galois form of x^32+x^22+x^2+x+1
  localparam logic [31:0] LFSR_TAPS = 32'h8020_0003;
  logic [31:0] lfsr_step;
  genvar gi;
  generate
    for (gi = 0; gi < 32; gi++) begin : g_lfsr
      if (gi == 31) begin : g_top
        assign lfsr_step[gi] = seq_word_reg[0] & LFSR_TAPS[gi];
      end else begin : g_mid
        assign lfsr_step[gi] = seq_word_reg[gi+1] ^ (seq_word_reg[0] & LFSR_TAPS[gi]);
      end
    end
  endgenerate
`endif

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      state_reg       <= IDLE;
      line_cnt_reg    <= '0;
      win_cnt_reg     <= '0;
      enable_reg      <= 1'b0;
      load_reg        <= 1'b0;
      err_reg         <= 1'b0;
      shadow_reg      <= '0;
      shadow_full_reg <= 1'b0;
      seq_word_reg    <= 32'h0000_0000;
    end else begin
      state_reg       <= state_next;
      line_cnt_reg    <= line_cnt_next;
      win_cnt_reg     <= win_cnt_next;
      enable_reg      <= enable_next;
      load_reg        <= load_next;
      err_reg         <= err_next;
      shadow_reg      <= shadow_next;
      shadow_full_reg <= shadow_full_next;
      seq_word_reg    <= seq_word_next;
    end
  end

  always_comb begin
    state_next    = state_reg;
    line_cnt_next = line_cnt_reg;
    win_cnt_next  = win_cnt_reg;
    enable_next   = enable_reg;
    load_next     = load_reg;
    err_next      = err_reg;

    // field_start outranks everything, including a coincident eav
    if (field_start) begin
      state_next    = COUNT;
      line_cnt_next = '0;
      win_cnt_next  = '0;
      enable_next   = 1'b0;
      load_next     = 1'b0;
      err_next      = 1'b0;
    end else begin
      case (state_reg)
        COUNT: begin
          if (sav) begin
            if (!(&line_cnt_reg)) line_cnt_next = line_cnt_reg + 1'b1;
            if (line_cnt_reg == TARGET) begin
              state_next   = INSERT;
              enable_next  = 1'b1;
              load_next    = LOAD_AT_SAV;
              win_cnt_next = WIN_W'(1);
            end
          end
        end
        INSERT: begin
          if (eav) begin
            state_next  = DONE;
            enable_next = 1'b0;
            load_next   = 1'b0;
            err_next    = 1'b1;
          end else if (win_cnt_reg == WIN_LAST) begin
            state_next  = DONE;
            enable_next = 1'b0;
            load_next   = 1'b0;
          end else begin
            // win_cnt holds the 1-based index of the window cycle now showing
            win_cnt_next = win_cnt_reg + 1'b1;
            load_next    = (win_cnt_reg < LOAD_LAST);
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    shadow_next      = shadow_reg;
    shadow_full_next = shadow_full_reg;
    seq_word_next    = seq_word_reg;

    if (field_start && shadow_full_reg) begin
      seq_word_next    = shadow_reg;
      shadow_full_next = 1'b0;
    end else if (field_start) begin
`ifdef SEQ_LFSR_ADVANCE_EN
      seq_word_next = (seq_word_reg == 32'h0) ? 32'h0000_0001 : lfsr_step;
`else
      seq_word_next = seq_word_reg;
`endif
    end

    // Only accepted while empty, so never collides with a commit
    if (seq_in_valid && !shadow_full_reg) begin
      shadow_next      = seq_in;
      shadow_full_next = 1'b1;
    end
  end

  assign seq_in_ready = ~shadow_full_reg;
  assign seq_word     = seq_word_reg;
  assign gen_enable   = enable_reg;
  assign insert_sel   = enable_reg;
  assign gen_load     = load_reg;
  assign err_short    = err_reg;

endmodule

// File: tb/tb_sequence_insert_ctrl.sv
// Self-checking bench for sequence_insert_ctrl: window timing via a cycle-stamped
// scoreboard, plus handshake, abort, reset and seq_word advance checks.
module tb_sequence_insert_ctrl;
  logic        clock = 1'b0;
  logic        rst_n = 1'b0;
  logic        field_start = 1'b0;
  logic        sav = 1'b0;
  logic        eav = 1'b0;
  logic [31:0] seq_in = 32'h0;
  logic        seq_in_valid = 1'b0;
  logic        seq_in_ready;
  logic [31:0] seq_word;
  logic        gen_enable;
  logic        gen_load;
  logic        insert_sel;
  logic        err_short;

  sequence_insert_ctrl dut (
    .clock        (clock),
    .rst_n        (rst_n),
    .field_start  (field_start),
    .sav          (sav),
    .eav          (eav),
    .seq_in       (seq_in),
    .seq_in_valid (seq_in_valid),
    .seq_in_ready (seq_in_ready),
    .seq_word     (seq_word),
    .gen_enable   (gen_enable),
    .gen_load     (gen_load),
    .insert_sel   (insert_sel),
    .err_short    (err_short)
  );

  always #5 clock = ~clock;

  int unsigned cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  typedef struct {
    int unsigned at;
    logic        en;
    logic        ld;
    string       tag;
  } exp_t;
  exp_t sb[$];

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
    end else begin
      $display("ok   %s: %h (cycle %0d)", tag, got, cyc);
    end
  endtask

  always @(negedge clock) begin
    exp_t e;
    while (sb.size() > 0 && sb[0].at < cyc) begin
      e = sb.pop_front();
      check_eq({e.tag, "_missed"}, cyc, e.at);
    end
    while (sb.size() > 0 && sb[0].at == cyc) begin
      e = sb.pop_front();
      check_eq({e.tag, "_en"},  gen_enable, e.en);
      check_eq({e.tag, "_ld"},  gen_load,   e.ld);
      check_eq({e.tag, "_sel"}, insert_sel, e.en);
    end
  end

  task automatic expect_at(input int unsigned at, input logic en, input logic ld, input string tag);
    exp_t e;
    e.at = at; e.en = en; e.ld = ld; e.tag = tag;
    sb.push_back(e);
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic pulse_fs();
    field_start = 1'b1; step(1); field_start = 1'b0;
  endtask

  task automatic pulse_sav();
    sav = 1'b1; step(1); sav = 1'b0;
  endtask

  task automatic pulse_eav();
    eav = 1'b1; step(1); eav = 1'b0;
  endtask

  task automatic run_lines(input int n, input int gap);
    repeat (n) begin
      pulse_sav();
      step(gap - 1);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned t;
    logic [31:0] lfsr_exp [3];
`ifdef SEQ_LFSR_ADVANCE_EN
    lfsr_exp[0] = 32'h0000_0001;
    lfsr_exp[1] = 32'h8020_0003;
    lfsr_exp[2] = 32'hC030_0002;
`else
    lfsr_exp[0] = 32'h0;
    lfsr_exp[1] = 32'h0;
    lfsr_exp[2] = 32'h0;
`endif

    // Reset values
    step(3);
    check_eq("rst_en",    gen_enable,   1'b0);
    check_eq("rst_ld",    gen_load,     1'b0);
    check_eq("rst_sel",   insert_sel,   1'b0);
    check_eq("rst_err",   err_short,    1'b0);
    check_eq("rst_ready", seq_in_ready, 1'b1);
    check_eq("rst_word",  seq_word,     32'h0);
    rst_n = 1'b1;
    step(2);

    // Full window on the 11th sav, with a word accepted mid-field
    pulse_fs();
    run_lines(5, 1716);
    seq_in = 32'hDEAD_BEEF;
    seq_in_valid = 1'b1;
    check_eq("hs_ready_before", seq_in_ready, 1'b1);
    step(1);
    seq_in_valid = 1'b0;
    seq_in = 32'h0;
    check_eq("hs_ready_after", seq_in_ready, 1'b0);
    run_lines(5, 1716);
    check_eq("hs_ready_held", seq_in_ready, 1'b0);
    t = cyc;
    expect_at(t,        1'b0, 1'b0, "win_pre");
    expect_at(t + 1,    1'b1, 1'b1, "win_first");
    expect_at(t + 36,   1'b1, 1'b1, "win_load_last");
    expect_at(t + 37,   1'b1, 1'b0, "win_load_off");
    expect_at(t + 1440, 1'b1, 1'b0, "win_last");
    expect_at(t + 1441, 1'b0, 1'b0, "win_off");
    pulse_sav();
    step(1445);
    check_eq("win_err", err_short, 1'b0);
    t = cyc;
    expect_at(t + 1, 1'b0, 1'b0, "done_sav_ignored");
    pulse_sav();
    step(2);

    // Commit on field_start, then early eav abort
    pulse_fs();
    check_eq("commit_word",  seq_word,     32'hDEAD_BEEF);
    check_eq("commit_ready", seq_in_ready, 1'b1);
    check_eq("commit_err",   err_short,    1'b0);
    run_lines(10, 200);
    t = cyc;
    expect_at(t + 1,   1'b1, 1'b1, "short_first");
    expect_at(t + 800, 1'b1, 1'b0, "short_last");
    expect_at(t + 801, 1'b0, 1'b0, "short_off");
    pulse_sav();
    step(799);
    pulse_eav();
    check_eq("short_err_set", err_short, 1'b1);
    step(5);
    field_start = 1'b1;
    eav = 1'b1;
    step(1);
    field_start = 1'b0;
    eav = 1'b0;
    check_eq("fs_eav_err_clear", err_short, 1'b0);

    // field_start aborts an open window; new field re-triggers
    run_lines(10, 200);
    t = cyc;
    expect_at(t + 1,   1'b1, 1'b1, "abort_first");
    expect_at(t + 500, 1'b1, 1'b0, "abort_last");
    expect_at(t + 501, 1'b0, 1'b0, "abort_off");
    pulse_sav();
    step(499);
    pulse_fs();
    run_lines(10, 200);
    t = cyc;
    expect_at(t + 1,  1'b1, 1'b1, "fresh_first");
    expect_at(t + 36, 1'b1, 1'b1, "fresh_load_last");
    expect_at(t + 37, 1'b1, 1'b0, "fresh_load_off");
    expect_at(t + 99, 1'b1, 1'b0, "fresh_before_rst");
    pulse_sav();
    step(98);
    #6;
    check_eq("sb_drained", sb.size(), 0);

    // Asynchronous reset in the middle of a window
    rst_n = 1'b0;
    #1;
    check_eq("arst_en",    gen_enable,   1'b0);
    check_eq("arst_ld",    gen_load,     1'b0);
    check_eq("arst_sel",   insert_sel,   1'b0);
    check_eq("arst_word",  seq_word,     32'h0);
    check_eq("arst_ready", seq_in_ready, 1'b1);
    step(2);
    rst_n = 1'b1;
    t = cyc;
    expect_at(t + 1, 1'b0, 1'b0, "post_rst_1");
    expect_at(t + 2, 1'b0, 1'b0, "post_rst_2");
    pulse_sav();
    step(3);

    // seq_word advance on field_start with no word offered
    for (int i = 0; i < 3; i++) begin
      pulse_fs();
      check_eq($sformatf("advance_%0d", i), seq_word, lfsr_exp[i]);
    end
    step(2);
    check_eq("sb_final", sb.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
